// File: rtl/cart_hdr_pkg.sv
// Shared constants, state encoding and size-code helper for the cartridge header loader.
package cart_hdr_pkg;

  localparam logic [14:0] HDR_TYPE       = 15'h0147;
  localparam logic [14:0] HDR_ROM        = 15'h0148;
  localparam logic [14:0] HDR_RAM        = 15'h0149;
  localparam logic [14:0] HDR_CSUM_FIRST = 15'h0134;
  localparam logic [14:0] HDR_CSUM       = 15'h014D;

  localparam logic [7:0] ROM_CODE_MAX = 8'd6;
  localparam logic [7:0] RAM_CODE_MAX = 8'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    GAP   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } hdr_state_e;

  // A 2 kB RAM is not a size the MBC decodes, so it is rounded up to 8 kB.
  function automatic logic [1:0] ram_code(input logic [7:0] raw);
    return (raw == 8'd1) ? 2'd2 : raw[1:0];
  endfunction

endpackage

// File: rtl/cart_hdr_checksum.sv
// Running header checksum: every strobed byte updates sum <= sum - byte - 1 (mod 256).
module cart_hdr_checksum (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clear_i,
  input  logic       strobe_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = 8'h00;
    end else if (strobe_i) begin
      sum_d = sum_q - data_i - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/cart_header_loader.sv
// Boot-time cartridge header reader that holds the MBC in reset until the sizes are known.
// Define CART_HEADER_CHECKSUM_EN to read 0x0134..0x014D and verify the header checksum.
module cart_header_loader
  import cart_hdr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nreset,
  output logic [14:0] mem_adr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  cart_type,
  output logic [2:0]  rom_size,
  output logic [1:0]  ram_size,
  output logic        mbc_reset,
  output logic        hdr_busy,
  output logic        hdr_valid,
  output logic        hdr_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

`ifdef CART_HEADER_CHECKSUM_EN
  localparam logic [14:0] START_ADR = HDR_CSUM_FIRST;
  localparam logic [14:0] END_ADR   = HDR_CSUM;
`else
  localparam logic [14:0] START_ADR = HDR_TYPE;
  localparam logic [14:0] END_ADR   = HDR_RAM;
`endif

  hdr_state_e  state_q, state_d;
  logic [14:0] adr_q, adr_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  romRaw_q, romRaw_d;
  logic [7:0]  ramRaw_q, ramRaw_d;
  logic [2:0]  romSize_q, romSize_d;
  logic [1:0]  ramSize_q, ramSize_d;
  logic        rangeBad;
  logic        csumBad;

`ifdef CART_HEADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] csumByte_q, csumByte_d;
  logic       sumClear, sumStrobe;

  assign sumClear  = (state_q == IDLE);
  assign sumStrobe = (state_q == REQ) && mem_ack && (adr_q != HDR_CSUM);

  cart_hdr_checksum u_checksum (
    .clk      (clk),
    .nreset   (nreset),
    .clear_i  (sumClear),
    .strobe_i (sumStrobe),
    .data_i   (mem_data),
    .sum_o    (sum)
  );

  always_comb begin
    csumByte_d = csumByte_q;
    if ((state_q == REQ) && mem_ack && (adr_q == HDR_CSUM)) begin
      csumByte_d = mem_data;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      csumByte_q <= 8'h00;
    end else begin
      csumByte_q <= csumByte_d;
    end
  end

  assign csumBad = (csumByte_q != sum);
`else
  assign csumBad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    tmo_d     = tmo_q;
    type_d    = type_q;
    romRaw_d  = romRaw_q;
    ramRaw_d  = ramRaw_q;
    romSize_d = romSize_q;
    ramSize_d = ramSize_q;
    rangeBad  = (romRaw_q > ROM_CODE_MAX) || (ramRaw_q > RAM_CODE_MAX);

    case (state_q)
      IDLE: begin
        adr_d   = START_ADR;
        tmo_d   = 8'h00;
        state_d = REQ;
      end
      REQ: begin
        if (mem_ack) begin
          if (adr_q == HDR_TYPE) type_d   = mem_data;
          if (adr_q == HDR_ROM)  romRaw_d = mem_data;
          if (adr_q == HDR_RAM)  ramRaw_d = mem_data;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      GAP: begin
        tmo_d = 8'h00;
        if (adr_q == END_ADR) begin
          state_d = CHECK;
        end else begin
          adr_d   = adr_q + 15'd1;
          state_d = REQ;
        end
      end
      CHECK: begin
        if (rangeBad || csumBad) begin
          state_d = ERR;
        end else begin
          // Sizes are published on the same edge that releases the MBC.
          romSize_d = romRaw_q[2:0];
          ramSize_d = ram_code(ramRaw_q);
          state_d   = DONE;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      adr_q     <= 15'h0000;
      tmo_q     <= 8'h00;
      type_q    <= 8'h00;
      romRaw_q  <= 8'h00;
      ramRaw_q  <= 8'h00;
      romSize_q <= 3'd0;
      ramSize_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      tmo_q     <= tmo_d;
      type_q    <= type_d;
      romRaw_q  <= romRaw_d;
      ramRaw_q  <= ramRaw_d;
      romSize_q <= romSize_d;
      ramSize_q <= ramSize_d;
    end
  end

  assign mem_adr   = adr_q;
  assign mem_rd    = (state_q == REQ);
  assign cart_type = type_q;
  assign rom_size  = romSize_q;
  assign ram_size  = ramSize_q;
  assign hdr_busy  = (state_q == REQ) || (state_q == GAP) || (state_q == CHECK);
  assign mbc_reset = !((state_q == DONE) || (state_q == ERR));
  assign hdr_valid = (state_q == DONE);
  assign hdr_err   = (state_q == ERR);

endmodule

// File: tb/tb_cart_header_loader.sv
// Scoreboard bench for cart_header_loader: randomized header images against a reference model.
`timescale 1ns/1ps
module tb_cart_header_loader;

`ifdef CART_HEADER_CHECKSUM_EN
  localparam int START = 'h134;
  localparam int LAST  = 'h14D;
`else
  localparam int START = 'h147;
  localparam int LAST  = 'h149;
`endif
  localparam int TIMEOUT = 255;

  typedef struct {
    logic [7:0] cartType;
    logic [2:0] rom;
    logic [1:0] ram;
    logic       valid;
    logic       err;
    int         nReads;
    int         runLen;
  } exp_t;

  logic        clk;
  logic        nreset;
  logic [14:0] mem_adr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  cart_type;
  logic [2:0]  rom_size;
  logic [1:0]  ram_size;
  logic        mbc_reset;
  logic        hdr_busy;
  logic        hdr_valid;
  logic        hdr_err;

  logic [7:0]  hdrMem [0:511];
  logic [14:0] readLog [$];
  exp_t        expQ [$];
  int          checks, errors;
  int          doneCnt;
  int          ackDelay, stallAt, rdHigh, lastRun;
  bit          respEn, stallEn, partialBad, bothHigh, gapBad;

  cart_header_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .mem_adr   (mem_adr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .cart_type (cart_type),
    .rom_size  (rom_size),
    .ram_size  (ram_size),
    .mbc_reset (mbc_reset),
    .hdr_busy  (hdr_busy),
    .hdr_valid (hdr_valid),
    .hdr_err   (hdr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Header checksum as defined for cartridges: x = x - byte - 1 over 0x0134..0x014C.
  function automatic logic [7:0] headerSum();
    logic [7:0] x;
    x = 8'h00;
    for (int a = 'h134; a <= 'h14C; a++) x = x - hdrMem[a] - 8'd1;
    return x;
  endfunction

  function automatic exp_t modelHeader(input bit stall, input int stallAdr);
    exp_t       e;
    logic [7:0] romRaw, ramRaw;
    bit         bad;
    romRaw   = hdrMem['h148];
    ramRaw   = hdrMem['h149];
    e.nReads = (stall ? stallAdr : LAST) - START + 1;
    e.runLen = stall ? TIMEOUT : 0;
    e.cartType = (!stall || stallAdr > 'h147) ? hdrMem['h147] : 8'h00;
    bad = stall || (romRaw > 8'd6) || (ramRaw > 8'd3);
`ifdef CART_HEADER_CHECKSUM_EN
    if (headerSum() != hdrMem['h14D]) bad = 1'b1;
`endif
    e.err   = bad;
    e.valid = !bad;
    e.rom   = bad ? 3'd0 : romRaw[2:0];
    e.ram   = bad ? 2'd0 : ((ramRaw == 8'd1) ? 2'd2 : ramRaw[1:0]);
    return e;
  endfunction

  // Memory responder: acks after ackDelay cycles of mem_rd and logs each read address once.
  initial begin
    mem_ack = 1'b0;
    mem_data = 8'h00;
    rdHigh = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!respEn) begin
        rdHigh = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        rdHigh = 0;
        if (mem_rd) gapBad = 1'b1;
      end else if (mem_rd) begin
        rdHigh++;
        if (rdHigh == 1) readLog.push_back(mem_adr);
        if (!(stallEn && int'(mem_adr) == stallAt) && rdHigh >= ackDelay) begin
          mem_ack = 1'b1;
          mem_data = hdrMem[mem_adr[8:0]];
        end
      end else begin
        if (rdHigh > 0) lastRun = rdHigh;
        rdHigh = 0;
      end
    end
  end

  // Monitor: compares against the scoreboard whenever the DUT releases the MBC.
  initial begin
    logic prevMbc;
    exp_t e;
    int   badAdr;
    prevMbc = 1'b1;
    forever begin
      @(negedge clk);
      if (hdr_valid && hdr_err) bothHigh = 1'b1;
      if (mbc_reset && (rom_size != 3'd0 || ram_size != 2'd0)) partialBad = 1'b1;
      if (prevMbc && !mbc_reset) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedDone: got release, expected none");
        end else begin
          e = expQ.pop_front();
          checkOutput("cartType", 32'(cart_type), 32'(e.cartType));
          checkOutput("romSize", 32'(rom_size), 32'(e.rom));
          checkOutput("ramSize", 32'(ram_size), 32'(e.ram));
          checkOutput("hdrValid", 32'(hdr_valid), 32'(e.valid));
          checkOutput("hdrErr", 32'(hdr_err), 32'(e.err));
          checkOutput("hdrBusy", 32'(hdr_busy), 32'd0);
          checkOutput("numReads", 32'(readLog.size()), 32'(e.nReads));
          badAdr = 0;
          foreach (readLog[i]) if (int'(readLog[i]) != START + i) badAdr++;
          checkOutput("readAddrs", 32'(badAdr), 32'd0);
          if (e.runLen > 0) checkOutput("rdRunLen", 32'(lastRun), 32'(e.runLen));
          checkOutput("sizesHeld", 32'(partialBad), 32'd0);
          checkOutput("readGap", 32'(gapBad), 32'd0);
          checkOutput("validErrExcl", 32'(bothHigh), 32'd0);
        end
        doneCnt++;
      end
      prevMbc = mbc_reset;
    end
  end

  task automatic checkReset();
    checkOutput("rstMemRd", 32'(mem_rd), 32'd0);
    checkOutput("rstMemAdr", 32'(mem_adr), 32'd0);
    checkOutput("rstCartType", 32'(cart_type), 32'd0);
    checkOutput("rstRomSize", 32'(rom_size), 32'd0);
    checkOutput("rstRamSize", 32'(ram_size), 32'd0);
    checkOutput("rstMbcReset", 32'(mbc_reset), 32'd1);
    checkOutput("rstBusy", 32'(hdr_busy), 32'd0);
    checkOutput("rstValid", 32'(hdr_valid), 32'd0);
    checkOutput("rstErr", 32'(hdr_err), 32'd0);
  endtask

  task automatic loadImage(input logic [7:0] typ, input logic [7:0] rom, input logic [7:0] ram,
                           input int delay, input bit stall, input int stallAdr, input bit csumFlip);
    nreset = 1'b0;
    respEn = 1'b0;
    mem_ack = 1'b0;
    for (int a = 0; a < 512; a++) hdrMem[a] = 8'($urandom);
    hdrMem['h147] = typ;
    hdrMem['h148] = rom;
    hdrMem['h149] = ram;
    hdrMem['h14D] = headerSum();
    if (csumFlip) hdrMem['h14D] = hdrMem['h14D] ^ 8'h01;
    ackDelay = delay;
    stallEn = stall;
    stallAt = stallAdr;
    readLog.delete();
    lastRun = 0;
    partialBad = 1'b0;
    bothHigh = 1'b0;
    gapBad = 1'b0;
  endtask

  task automatic waitComplete(input int target);
    int cyc;
    cyc = 0;
    while (doneCnt < target && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    checkOutput("completed", 32'(doneCnt >= target), 32'd1);
    if (doneCnt < target) expQ.delete();
  endtask

  task automatic applyStimulus(input logic [7:0] typ, input logic [7:0] rom, input logic [7:0] ram,
                               input int delay, input bit stall, input int stallAdr, input bit csumFlip);
    int target;
    loadImage(typ, rom, ram, delay, stall, stallAdr, csumFlip);
    expQ.push_back(modelHeader(stall, stallAdr));
    target = doneCnt + 1;
    repeat (2) @(posedge clk);
    #2;
    nreset = 1'b1;
    respEn = 1'b1;
    waitComplete(target);
  endtask

  task automatic midReadReset();
    int target;
    bit found;
    loadImage(8'h1B, 8'h05, 8'h02, 4, 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    nreset = 1'b1;
    respEn = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 500 && !found; cyc++) begin
      @(posedge clk);
      #2;
      if (mem_rd && mem_adr == 15'h0148) found = 1'b1;
    end
    checkOutput("reachedRomRead", 32'(found), 32'd1);
    respEn = 1'b0;
    nreset = 1'b0;
    #1;
    checkReset();
    mem_ack = 1'b1;
    mem_data = 8'h07;
    repeat (2) @(posedge clk);
    mem_ack = 1'b0;
    readLog.delete();
    gapBad = 1'b0;
    partialBad = 1'b0;
    expQ.push_back(modelHeader(1'b0, 0));
    target = doneCnt + 1;
    #2;
    nreset = 1'b1;
    respEn = 1'b1;
    waitComplete(target);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    doneCnt = 0;
    respEn = 1'b0;
    stallEn = 1'b0;
    ackDelay = 2;
    nreset = 1'b1;
    #2;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset();

    applyStimulus(8'h03, 8'h04, 8'h03, 2, 1'b0, 0, 1'b0);
    applyStimulus(8'h11, 8'h07, 8'h00, 2, 1'b0, 0, 1'b0);
    applyStimulus(8'h01, 8'h02, 8'h01, 1, 1'b0, 0, 1'b0);
    applyStimulus(8'h01, 8'h02, 8'h05, 3, 1'b0, 0, 1'b0);
    applyStimulus(8'h05, 8'h06, 8'h02, 1, 1'b0, 0, 1'b0);
`ifdef CART_HEADER_CHECKSUM_EN
    applyStimulus(8'h03, 8'h04, 8'h03, 2, 1'b0, 0, 1'b1);
`endif

    applyStimulus(8'h13, 8'h03, 8'h02, 2, 1'b1, 'h148, 1'b0);
    respEn = 1'b0;
    mem_ack = 1'b1;
    mem_data = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("lateAckErr", 32'(hdr_err), 32'd1);
    checkOutput("lateAckValid", 32'(hdr_valid), 32'd0);
    checkOutput("lateAckRom", 32'(rom_size), 32'd0);
    checkOutput("lateAckType", 32'(cart_type), 32'h13);
    checkOutput("lateAckMbc", 32'(mbc_reset), 32'd0);

    midReadReset();

    for (int n = 0; n < 12; n++) begin
      applyStimulus(8'($urandom), 8'($urandom_range(0, 8)), 8'($urandom_range(0, 5)),
                    $urandom_range(1, 4), 1'b0, 0, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_header_loader.md
Name: cart_header_loader

Overview:
- Boot-time sequencer ahead of the cartridge MBC: after reset it reads cartridge header bytes 0x0147 (type), 0x0148 (ROM size) and 0x0149 (RAM size) over a simple request/acknowledge read port.
- It drives rom_size/ram_size into the MBC and holds the MBC in reset until the header has been read and range-checked.
- On any fault it releases the MBC with safe defaults: 32 kB ROM, no RAM.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_rd may wait for mem_ack before the load is aborted; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- nreset  in  1  asynchronous, active-low reset.
- mem_adr  out  15  header byte address (cartridge address space, A14..A0).
- mem_rd  out  1  read request; held with stable mem_adr until acknowledged.
- mem_ack  in  1  read acknowledge; mem_data is valid in the same cycle.
- mem_data  in  8  read data.
- cart_type  out  8  raw byte 0x0147.
- rom_size  out  3  ROM size code for the MBC, 0..6.
- ram_size  out  2  RAM size code for the MBC: 0 = none, 2 = 8 kB, 3 = 32 kB.
- mbc_reset  out  1  active-high reset to the MBC; high until loading finishes.
- hdr_busy  out  1  high while loading.
- hdr_valid  out  1  high when the header loaded and passed all checks.
- hdr_err  out  1  high when loading failed (timeout, out-of-range value, or checksum mismatch).

Behaviour:
- Async reset values: state IDLE; mem_rd=0; mem_adr=0; cart_type=0; rom_size=0; ram_size=0; mbc_reset=1; hdr_busy=0; hdr_valid=0; hdr_err=0; timeout counter=0.
- Reset is honoured at any point, including mid-read. After reset deasserts, the sequence restarts from IDLE. Any mem_ack arriving for an aborted read is ignored.
- States: IDLE -> REQ -> GAP -> (REQ | CHECK) -> DONE or ERR.
  - IDLE: on the first clock after reset release, set hdr_busy=1, load the address counter with START_ADR, go to REQ.
  - REQ: mem_rd=1, mem_adr=address counter. Count cycles without ack.
    - Ack sampled: capture mem_data into the matching slot (0x0147->cart_type reg, 0x0148->rom raw, 0x0149->ram raw; others feed only the checksum). Drop mem_rd next cycle. Go to GAP.
    - No ack after TIMEOUT_CYCLES cycles: go to ERR.
    - Read latency is therefore >= 1 cycle per byte. mem_rd is never high on two consecutive reads without an intervening low cycle.
  - GAP: one idle cycle with mem_rd=0.
    - If address counter == END_ADR: go to CHECK.
    - Otherwise increment the counter and go to REQ.
  - CHECK (one cycle):
    - rom raw > 6: ERR.
    - ram raw > 3: ERR. ram raw 1 (2 kB) maps to code 2; 0, 2, 3 map unchanged.
    - Otherwise go to DONE.
  - DONE: drive rom_size/ram_size from the checked values; hdr_valid=1, hdr_busy=0, mbc_reset=0 (all in the same cycle). Terminal until reset.
  - ERR: rom_size=0, ram_size=0, cart_type keeps the last captured value; hdr_err=1, hdr_busy=0, mbc_reset=0. Terminal until reset.
- rom_size/ram_size stay 0 throughout loading. They change in the same cycle mbc_reset falls, so the MBC never sees partial values.
- hdr_valid and hdr_err are mutually exclusive and never both high.
- Without the optional feature: START_ADR=0x0147, END_ADR=0x0149 (3 reads).

Optional Feature:
- Macro: CART_HEADER_CHECKSUM_EN.
- Defined:
  - START_ADR=0x0134, END_ADR=0x014D (26 reads).
  - 8-bit accumulator x cleared in IDLE; for each byte at 0x0134..0x014C, x <= x - byte - 1 (mod 256).
  - Byte 0x014D is compared with x in CHECK. A mismatch goes to ERR; the range checks still apply.
- Undefined: no accumulator or comparator logic; address range as above.

Decomposition:
- Package cart_hdr_pkg holds:
  - address constants: HDR_TYPE=0x0147, HDR_ROM=0x0148, HDR_RAM=0x0149, HDR_CSUM_FIRST=0x0134, HDR_CSUM=0x014D;
  - the state encoding (IDLE, REQ, GAP, CHECK, DONE, ERR);
  - the max codes ROM_CODE_MAX=6 and RAM_CODE_MAX=3.
- One sub-module: cart_hdr_checksum (clear, byte strobe, data in, 8-bit sum out). It is instantiated only under CART_HEADER_CHECKSUM_EN.

Test Plan:
- Feature off; memory acks 2 cycles after mem_rd with 0x0147=0x03, 0x0148=0x04, 0x0149=0x03 -> exactly 3 reads at 0x147/0x148/0x149; then cart_type=0x03, rom_size=4, ram_size=3, hdr_valid=1, and mbc_reset falls in the same cycle the sizes appear.
- 0x0148=0x07 -> hdr_err=1, rom_size=0, ram_size=0, mbc_reset=0, hdr_valid=0.
- 0x0149=0x01 -> ram_size=2, hdr_valid=1. Separately, 0x0149=0x05 -> hdr_err=1.
- Memory never acks at 0x0148 -> mem_rd high for exactly 255 cycles, then ERR with hdr_err=1. A late ack afterwards has no effect.
- Feature on; header bytes with the correct 0x014D -> 26 reads 0x0134..0x014D, hdr_valid=1. Flip 0x014D by 1 -> hdr_err=1 with sizes 0.
- Assert nreset low mid-read (during REQ at 0x0148) -> all outputs return to reset values immediately. After release, reads restart at START_ADR.
